// File: rtl/mc_ctrl.sv
`default_nettype none
// mc_ctrl: multi-cycle RV32I sequencer with memory watchdog and halt/fault status. Rev 1.0
// Optional macro CTRL_PERF_CNT_EN enables the cycle_cnt/instret performance counters.
module mc_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  cls,
  input  logic [2:0]  funct3,
  input  logic        br_taken,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic        halt,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret
);
  localparam int TW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int WD_LAST_I = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [TW-1:0] WD_LAST = TW'(WD_LAST_I);

  localparam int C_LOAD   = 0;
  localparam int C_STORE  = 1;
  localparam int C_BRANCH = 2;
  localparam int C_JALR   = 3;
  localparam int C_JAL    = 4;
  localparam int C_LUI    = 5;
  localparam int C_AUIPC  = 6;
  localparam int C_OPIMM  = 7;
  localparam int C_OP     = 8;
  localparam int C_SYSTEM = 9;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [9:0]    r_cls;
  logic [2:0]    r_funct3;
  logic [TW-1:0] r_wdog;
  logic [1:0]    r_cause, w_cause_nxt;
  logic          w_wd_expired, w_cls_onehot, w_waiting;

  assign w_cls_onehot = (cls != 10'd0) && ((cls & (cls - 10'd1)) == 10'd0);
  assign w_waiting    = (r_state == S_FETCH) || (r_state == S_MEM);
  // Expiry is flagged on the last allowed wait cycle so an ack in that cycle still wins.
  assign w_wd_expired = (MEM_TIMEOUT != 0) && (r_wdog == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cls    <= '0;
      r_funct3 <= '0;
      r_wdog   <= '0;
      r_cause  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cause <= w_cause_nxt;
      if (r_state == S_DECODE) begin
        r_cls    <= cls;
        r_funct3 <= funct3;
      end
      if (w_state_nxt != r_state) begin
        r_wdog <= '0;
      end else if (w_waiting && (r_wdog != '1)) begin
        r_wdog <= r_wdog + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cause_nxt = r_cause;
    imem_req    = 1'b0;
    ir_we       = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = 2'd0;
    rf_we       = 1'b0;
    wb_sel      = 2'd0;
    case (r_state)
      S_IDLE: w_state_nxt = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we       = 1'b1;
          w_state_nxt = S_DECODE;
        end else if (w_wd_expired) begin
          w_state_nxt = S_FAULT;
          w_cause_nxt = 2'd2;
        end
      end
      S_DECODE: begin
        if (w_cls_onehot) begin
          w_state_nxt = S_EXEC;
        end else begin
          w_state_nxt = S_FAULT;
          w_cause_nxt = 2'd1;
        end
      end
      S_EXEC: begin
        if (r_cls[C_BRANCH]) begin
          pc_we       = 1'b1;
          pc_sel      = br_taken ? 2'd1 : 2'd0;
          w_state_nxt = S_FETCH;
        end else if (r_cls[C_JAL] || r_cls[C_JALR]) begin
          rf_we       = 1'b1;
          wb_sel      = 2'd2;
          pc_we       = 1'b1;
          pc_sel      = r_cls[C_JALR] ? 2'd2 : 2'd1;
          w_state_nxt = S_FETCH;
        end else if (r_cls[C_LOAD] || r_cls[C_STORE]) begin
          w_state_nxt = S_MEM;
        end else if (r_cls[C_LUI] || r_cls[C_AUIPC] || r_cls[C_OP] || r_cls[C_OPIMM]) begin
          w_state_nxt = S_WB;
        end else if (r_cls[C_SYSTEM] && (r_funct3 == 3'd0)) begin
          w_state_nxt = S_HALT;
        end else begin
          w_state_nxt = S_FAULT;
          w_cause_nxt = 2'd1;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = r_cls[C_STORE];
        if (dmem_ack) begin
          if (r_cls[C_STORE]) begin
            pc_we       = 1'b1;
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_WB;
          end
        end else if (w_wd_expired) begin
          w_state_nxt = S_FAULT;
          w_cause_nxt = 2'd3;
        end
      end
      S_WB: begin
        rf_we       = 1'b1;
        wb_sel      = r_cls[C_LOAD] ? 2'd1 : 2'd0;
        pc_we       = 1'b1;
        w_state_nxt = S_FETCH;
      end
      default: ;
    endcase
  end

  assign state       = r_state;
  assign halt        = (r_state == S_HALT);
  assign fault       = (r_state == S_FAULT);
  assign fault_cause = r_cause;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] r_cycle_cnt, r_instret;
  logic        w_active, w_retire;

  assign w_active = (r_state >= S_FETCH) && (r_state <= S_WB);
  assign w_retire = (w_state_nxt == S_FETCH) &&
                    ((r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt <= '0;
      r_instret   <= '0;
    end else begin
      if (w_active) r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (w_retire) r_instret   <= r_instret + 32'd1;
    end
  end

  assign cycle_cnt = r_cycle_cnt;
  assign instret   = r_instret;
`else
  assign cycle_cnt = '0;
  assign instret   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// tb_mc_ctrl: table-driven directed bench for mc_ctrl built with MEM_TIMEOUT=4.
module tb_mc_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  cls = '0;
  logic [2:0]  funct3 = '0;
  logic        br_taken = 1'b0;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we, halt, fault;
  logic [1:0]  pc_sel, wb_sel, fault_cause;
  logic [2:0]  state;
  logic [31:0] cycle_cnt, instret;
  logic [16:0] all_outs;
  logic [5:0]  strobes;

  always #5 clk = ~clk;

  mc_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .cls(cls), .funct3(funct3), .br_taken(br_taken),
    .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
    .state(state), .halt(halt), .fault(fault), .fault_cause(fault_cause),
    .cycle_cnt(cycle_cnt), .instret(instret)
  );

  assign all_outs = {imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, rf_we, wb_sel,
                     state, halt, fault, fault_cause};
  assign strobes  = {imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we};

  typedef struct packed {
    logic [9:0] cls;
    logic [2:0] f3;
    logic       br;
    int         dly;
    int         cyc;
    int         rfw;
    int         wbs;
    int         pcw;
    int         pcs;
    int         dreq;
    int         dwe;
  } vec_t;

  vec_t vecs [12];
  int total = 0;
  int bad = 0;
  int cyc, irw_at, rfw, wbs, pcw, pcs, dreq, dwe, cnt;
  logic [5:0] acc;

  function automatic vec_t mk(input logic [9:0] c, input logic [2:0] f, input logic b,
                              input int d, input int cy, input int rw, input int ws,
                              input int pw, input int ps, input int dr, input int dw);
    vec_t v;
    v.cls = c; v.f3 = f; v.br = b; v.dly = d; v.cyc = cy; v.rfw = rw; v.wbs = ws;
    v.pcw = pw; v.pcs = ps; v.dreq = dr; v.dwe = dw;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; cls = '0; funct3 = '0; br_taken = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  // Starts in FETCH; acks the fetch at once and presents c/f during DECODE only.
  task automatic fetch_and_decode(input logic [9:0] c, input logic [2:0] f);
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    cls = c; funct3 = f;
    step();
    cls = 10'h3ff; funct3 = ~f;
  endtask

  // Starts in the first FETCH cycle; returns in the first cycle of the next FETCH.
  task automatic run_instr(input vec_t v, output int o_cyc, output int o_irw, output int o_rfw,
                           output int o_wbs, output int o_pcw, output int o_pcs,
                           output int o_dreq, output int o_dwe);
    int fc, mc;
    o_cyc = 0; o_irw = -1; o_rfw = 0; o_wbs = 0; o_pcw = 0; o_pcs = 0; o_dreq = 0; o_dwe = 0;
    fc = 0; mc = 0;
    br_taken = v.br;
    do begin
      imem_ack = (state == 3'd1) && (fc == 1);
      dmem_ack = (state == 3'd4) && (mc == v.dly);
      cls      = (state == 3'd2) ? v.cls : 10'h3ff;
      funct3   = (state == 3'd2) ? v.f3 : ~v.f3;
      #1;
      if (ir_we) o_irw = o_cyc;
      if (rf_we) begin o_rfw++; o_wbs = int'(wb_sel); end
      if (pc_we) begin o_pcw++; o_pcs = int'(pc_sel); end
      if (dmem_req) begin o_dreq++; o_dwe = o_dwe | int'(dmem_we); end
      if (state == 3'd1) fc++;
      if (state == 3'd4) mc++;
      o_cyc++;
      step();
    end while (o_cyc < 50 && !(state == 3'd1 && fc >= 2));
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
  endtask

  initial begin
    //                 cls      f3    br  dly cyc rfw wbs pcw pcs dreq dwe
    vecs[0]  = mk(10'h100, 3'd5, 1'b0, 0, 5, 1, 0, 1, 0, 0, 0);
    vecs[1]  = mk(10'h080, 3'd0, 1'b0, 0, 5, 1, 0, 1, 0, 0, 0);
    vecs[2]  = mk(10'h020, 3'd3, 1'b0, 0, 5, 1, 0, 1, 0, 0, 0);
    vecs[3]  = mk(10'h040, 3'd7, 1'b0, 0, 5, 1, 0, 1, 0, 0, 0);
    vecs[4]  = mk(10'h001, 3'd2, 1'b0, 3, 9, 1, 1, 1, 0, 4, 0);
    vecs[5]  = mk(10'h001, 3'd0, 1'b0, 0, 6, 1, 1, 1, 0, 1, 0);
    vecs[6]  = mk(10'h002, 3'd2, 1'b0, 0, 5, 0, 0, 1, 0, 1, 1);
    vecs[7]  = mk(10'h002, 3'd1, 1'b0, 2, 7, 0, 0, 1, 0, 3, 1);
    vecs[8]  = mk(10'h004, 3'd0, 1'b1, 0, 4, 0, 0, 1, 1, 0, 0);
    vecs[9]  = mk(10'h004, 3'd1, 1'b0, 0, 4, 0, 0, 1, 0, 0, 0);
    vecs[10] = mk(10'h010, 3'd0, 1'b0, 0, 4, 1, 2, 1, 1, 0, 0);
    vecs[11] = mk(10'h008, 3'd0, 1'b1, 0, 4, 1, 2, 1, 2, 0, 0);

    repeat (2) step();
    check("reset outputs", int'(all_outs), 0);
    check("reset cycle_cnt", int'(cycle_cnt), 0);
    rst_n = 1'b1;
    #1;
    check("idle after release", int'(state), 0);
    step();
    check("fetch after idle", int'(state), 1);
    check("imem_req in fetch", int'(imem_req), 1);

    for (int i = 0; i < 12; i++) begin
      run_instr(vecs[i], cyc, irw_at, rfw, wbs, pcw, pcs, dreq, dwe);
      check($sformatf("v%0d cycles", i), cyc, vecs[i].cyc);
      check($sformatf("v%0d ir_we cycle", i), irw_at, 1);
      check($sformatf("v%0d rf_we count", i), rfw, vecs[i].rfw);
      check($sformatf("v%0d wb_sel", i), wbs, vecs[i].wbs);
      check($sformatf("v%0d pc_we count", i), pcw, vecs[i].pcw);
      check($sformatf("v%0d pc_sel", i), pcs, vecs[i].pcs);
      check($sformatf("v%0d dmem_req cycles", i), dreq, vecs[i].dreq);
      check($sformatf("v%0d dmem_we", i), dwe, vecs[i].dwe);
      if (i == 2) begin
`ifdef CTRL_PERF_CNT_EN
        check("instret after 3 alu", int'(instret), 3);
        check("cycle_cnt after 3 alu", int'(cycle_cnt), 15);
`else
        check("instret tied off", int'(instret), 0);
        check("cycle_cnt tied off", int'(cycle_cnt), 0);
`endif
      end
    end

    dmem_ack = 1'b1;
    #1;
    check("spurious dmem_ack req", int'(dmem_req), 0);
    step();
    dmem_ack = 1'b0;
    check("spurious dmem_ack state", int'(state), 1);

    do_reset();
    fetch_and_decode(10'h000, 3'd0);
    check("cls zero state", int'(state), 7);
    check("cls zero cause", int'(fault_cause), 1);
    acc = '0;
    for (int k = 0; k < 20; k++) begin
      imem_ack = k[0];
      dmem_ack = ~k[0];
      #1;
      acc = acc | strobes;
      step();
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    check("fault strobes 20 cycles", int'(acc), 0);
    check("fault sticky", int'({halt, fault, fault_cause}), 3'b0 + 5);

    do_reset();
    fetch_and_decode(10'h003, 3'd0);
    check("cls two-hot state", int'(state), 7);
    check("cls two-hot cause", int'(fault_cause), 1);

    do_reset();
    fetch_and_decode(10'h200, 3'd0);
    step();
    check("ecall state", int'(state), 6);
    check("ecall halt/fault/cause", int'({halt, fault, fault_cause}), 8);

    do_reset();
    fetch_and_decode(10'h200, 3'd1);
    step();
    check("csr state", int'(state), 7);
    check("csr cause", int'(fault_cause), 1);

    do_reset();
    cnt = 0;
    for (int k = 0; k < 10 && state == 3'd1; k++) begin
      if (imem_req) cnt++;
      step();
    end
    check("imem timeout wait cycles", cnt, 4);
    check("imem timeout state", int'(state), 7);
    check("imem timeout cause", int'(fault_cause), 2);

    do_reset();
    repeat (3) step();
    check("fetch still waiting", int'(state), 1);
    imem_ack = 1'b1;
    #1;
    check("late ack ir_we", int'(ir_we), 1);
    step();
    imem_ack = 1'b0;
    check("late ack decode", int'(state), 2);

    do_reset();
    fetch_and_decode(10'h001, 3'd2);
    step();
    cnt = 0;
    for (int k = 0; k < 10 && state == 3'd4; k++) begin
      if (dmem_req) cnt++;
      step();
    end
    check("dmem timeout wait cycles", cnt, 4);
    check("dmem timeout state", int'(state), 7);
    check("dmem timeout cause", int'(fault_cause), 3);

    do_reset();
    fetch_and_decode(10'h002, 3'd2);
    step();
    check("store mem req", int'({dmem_req, dmem_we}), 3);
    rst_n = 1'b0;
    #1;
    check("async reset outputs", int'(all_outs), 0);
    step();
    rst_n = 1'b1;
    step();
    check("fetch after async reset", int'(state), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
